// File: rtl/arb_pkg.sv
// Shared constants, state codes and mask helper for the 8-way round-robin arbiter.
// Imported by the priority encoder and the arbiter top.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits at or above the pointer are the round-robin candidates.
  function automatic logic [NREQ-1:0] ge_mask(input logic [IDXW-1:0] p);
    logic [NREQ-1:0] m;
    for (int i = 0; i < NREQ; i++) begin
      m[i] = (i >= int'(p));
    end
    return m;
  endfunction

endpackage

// File: rtl/prio_enc_8to3_lsb.sv
// Lowest-index-first 8:3 priority encoder.
// Ports: in (8 request bits), idx (index of lowest set bit), valid (any bit set).
module prio_enc_8to3_lsb
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] in,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = |in;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (in[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold/release handshake and hold limit.
// Ports: clk, rst_n (sync, low), en, req[7:0] -> gnt[7:0], gnt_idx[2:0], gnt_valid, timeout_pulse.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout_pulse
);

  localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            tp_q, tp_d;

  logic [IDXW-1:0] hi_idx, lo_idx, sel;
  logic            hi_vld, lo_vld;
  logic            held, at_limit;

  prio_enc_8to3_lsb u_enc_hi (
    .in    (req & ge_mask(ptr_q)),
    .idx   (hi_idx),
    .valid (hi_vld)
  );

  prio_enc_8to3_lsb u_enc_lo (
    .in    (req),
    .idx   (lo_idx),
    .valid (lo_vld)
  );

  // Fall back to the raw vector when nothing sits at or above ptr.
  assign sel      = hi_vld ? hi_idx : lo_idx;
  assign held     = req[idx_q];
  assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      tp_q    <= tp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    tp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && lo_vld) begin
          state_d = GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          idx_d   = sel;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!held || at_limit) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q + 1'b1;
          // A simultaneous release wins over the limit.
          tp_d    = held;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  assign gnt           = gnt_q;
  assign gnt_idx       = idx_q;
  assign gnt_valid     = (state_q == GRANT);
  assign timeout_pulse = tp_q;

endmodule
